sent_rx_fast_decoder: RTL

SENT receiver front end, the receiving end of the SENT fast channel. It samples the single-wire SENT line and measures falling-edge-to-falling-edge periods in ticks. It decodes the sync, status, three data nibbles and the CRC nibble, checks the CRC, and pushes each good 12-bit fast-channel word into an RX FIFO. It sits between the SENT pin and the RX FIFO and shares the tick-time scheme (divide_i) with the transmit side.

---
 rtl/sent_rx_fast_decoder.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sent_rx_fast_decoder.sv
// -----------------------------------------------------------------------------
// sent_rx_fast_decoder
//
// Receive side of a SENT fast channel. The SENT pin is synchronised, and the
// time between falling edges is measured in ticks. One tick is divide_i clk_rx
// cycles. Each period is classified as SYNC, NIBBLE or bad. The decoder
// assembles status + 3 data nibbles, checks the 4-bit CRC and writes good
// 12-bit words to an external RX FIFO.
//
// Optional feature: define SENT_RX_PAUSE_EN to accept a pause pulse
// (12..768 ticks, not SYNC) after the CRC nibble without raising an error.
//
// Ports:
//   clk_rx            block clock
//   reset_n_rx        asynchronous active-low reset
//   enable_i          decoder enable; low forces IDLE
//   divide_i[7:0]     clk_rx cycles per tick (0 behaves as 1)
//   sent_rx_i         SENT line (asynchronous)
//   data_fast_o[11:0] last good data word, D0 in [11:8]
//   status_o[3:0]     last good status nibble
//   write_enable_rx_o one-cycle FIFO write strobe
//   fifo_rx_full_i    RX FIFO full
//   frame_valid_o     one-cycle pulse, frame with correct CRC
//   crc_err_o         one-cycle pulse, CRC mismatch
//   pulse_err_o       one-cycle pulse, bad period or timeout
//   overflow_o        one-cycle pulse, good frame dropped (FIFO full)
// -----------------------------------------------------------------------------
module sent_rx_fast_decoder #(
    parameter int TICK_W        = 10,
    parameter int SYNC_TOL      = 1,
    parameter int TIMEOUT_TICKS = 800
) (
    input  logic        clk_rx,
    input  logic        reset_n_rx,
    input  logic        enable_i,
    input  logic [7:0]  divide_i,
    input  logic        sent_rx_i,
    output logic [11:0] data_fast_o,
    output logic [3:0]  status_o,
    output logic        write_enable_rx_o,
    input  logic        fifo_rx_full_i,
    output logic        frame_valid_o,
    output logic        crc_err_o,
    output logic        pulse_err_o,
    output logic        overflow_o
);

    localparam int PW = TICK_W + 1;   // period width: saturated ticks + rounding bit

    localparam logic [PW-1:0]     SYNC_LO   = PW'(56 - SYNC_TOL);
    localparam logic [PW-1:0]     SYNC_HI   = PW'(56 + SYNC_TOL);
    localparam logic [PW-1:0]     NIB_LO    = PW'(12);
    localparam logic [PW-1:0]     NIB_HI    = PW'(27);
    localparam logic [PW-1:0]     PAUSE_HI  = PW'(768);
    localparam logic [TICK_W-1:0] TIMEOUT_T = TICK_W'(TIMEOUT_TICKS);
    localparam logic [3:0]        CRC_SEED  = 4'b0101;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        STATUS,
        DATA,
        CRC,
        AFTER_CRC
    } state_t;

    // CRC step table, indexed by the running CRC value.
    function automatic logic [3:0] crc_tab(input logic [3:0] idx);
        logic [3:0] r;
        case (idx)
            4'd0:  r = 4'd0;
            4'd1:  r = 4'd13;
            4'd2:  r = 4'd7;
            4'd3:  r = 4'd10;
            4'd4:  r = 4'd14;
            4'd5:  r = 4'd3;
            4'd6:  r = 4'd9;
            4'd7:  r = 4'd4;
            4'd8:  r = 4'd1;
            4'd9:  r = 4'd12;
            4'd10: r = 4'd6;
            4'd11: r = 4'd11;
            4'd12: r = 4'd15;
            4'd13: r = 4'd2;
            4'd14: r = 4'd8;
            default: r = 4'd5;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    // [0],[1] form the 2-flop synchroniser, [2] is the edge register.
    logic [2:0]        sync_reg;
    logic              fall;

    // Reset to line-idle (high) so that reset release never looks like an edge.
    assign fall = sync_reg[2] & ~sync_reg[1];

    // ------------------------------------------------------------------
    // Tick measurement
    // ------------------------------------------------------------------
    logic [7:0]        presc_reg;
    logic [TICK_W-1:0] ticks_reg;
    logic [7:0]        div_eff;
    logic [7:0]        div_half;
    logic              round_up;
    logic [PW-1:0]     period;

    assign div_eff  = (divide_i == 8'd0) ? 8'd1 : divide_i;
    assign div_half = div_eff >> 1;
    // Round to the nearest tick, so that an edge a few clocks early still
    // counts as the full tick.
    assign round_up = (presc_reg >= div_half);
    assign period   = {1'b0, ticks_reg} + {{TICK_W{1'b0}}, round_up};

    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            sync_reg  <= 3'b111;
            presc_reg <= 8'd0;
            ticks_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], sent_rx_i};
            if (fall) begin
                presc_reg <= 8'd0;
                ticks_reg <= '0;
            end else if (presc_reg >= div_eff - 8'd1) begin
                presc_reg <= 8'd0;
                if (ticks_reg != {TICK_W{1'b1}})
                    ticks_reg <= ticks_reg + TICK_W'(1);
            end else begin
                presc_reg <= presc_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Period classification
    // ------------------------------------------------------------------
    logic       is_sync;
    logic       is_nib;
    logic       pause_ok;
    logic [3:0] nib_val;

    assign is_sync = (period >= SYNC_LO) && (period <= SYNC_HI);
    assign is_nib  = (period >= NIB_LO) && (period <= NIB_HI);
    // (period - 12) modulo 16 only needs the low bits.
    assign nib_val = period[3:0] - 4'd12;

`ifdef SENT_RX_PAUSE_EN
    assign pause_ok = (period >= NIB_LO) && (period <= PAUSE_HI);
`else
    assign pause_ok = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [3:0] crc_reg, crc_next;
    logic [1:0] idx_reg, idx_next;
    logic [3:0] status_rx_reg, status_rx_next;
    logic [11:0] data_rx_reg, data_rx_next;
    logic [11:0] data_out_reg, data_out_next;
    logic [3:0] status_out_reg, status_out_next;
    logic       we_reg, we_next;
    logic       valid_reg, valid_next;
    logic       crc_err_reg, crc_err_next;
    logic       pulse_err_reg, pulse_err_next;
    logic       ovf_reg, ovf_next;
    logic       bad;

    always_comb begin
        state_next      = state_reg;
        crc_next        = crc_reg;
        idx_next        = idx_reg;
        status_rx_next  = status_rx_reg;
        data_rx_next    = data_rx_reg;
        data_out_next   = data_out_reg;
        status_out_next = status_out_reg;
        we_next         = 1'b0;
        valid_next      = 1'b0;
        crc_err_next    = 1'b0;
        pulse_err_next  = 1'b0;
        ovf_next        = 1'b0;
        bad             = 1'b0;

        if (!enable_i) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state_reg)
                IDLE: state_next = WAIT_SYNC;
                WAIT_SYNC: begin
                    if (is_sync)
                        state_next = STATUS;
                end
                STATUS: begin
                    if (is_nib) begin
                        status_rx_next = nib_val;
                        crc_next       = CRC_SEED;
                        idx_next       = 2'd0;
                        state_next     = DATA;
                    end else begin
                        bad = 1'b1;
                    end
                end
                DATA: begin
                    if (is_nib) begin
                        crc_next     = crc_tab(crc_reg) ^ nib_val;
                        data_rx_next = {data_rx_reg[7:0], nib_val};
                        if (idx_reg == 2'd2)
                            state_next = CRC;
                        else
                            idx_next = idx_reg + 2'd1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                CRC: begin
                    if (is_nib) begin
                        if (nib_val == crc_tab(crc_reg)) begin
                            valid_next      = 1'b1;
                            data_out_next   = data_rx_reg;
                            status_out_next = status_rx_reg;
                            we_next         = ~fifo_rx_full_i;
                            ovf_next        = fifo_rx_full_i;
                        end else begin
                            crc_err_next = 1'b1;
                        end
                        state_next = AFTER_CRC;
                    end else begin
                        bad = 1'b1;
                    end
                end
                AFTER_CRC: begin
                    if (is_sync)
                        state_next = STATUS;
                    else if (pause_ok)
                        state_next = WAIT_SYNC;
                    else
                        bad = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if ((state_reg != IDLE) && (state_reg != WAIT_SYNC) &&
                     (ticks_reg >= TIMEOUT_T)) begin
            bad = 1'b1;
        end

        // A bad pulse consumes its edge; the frame restarts from the next sync.
        if (bad) begin
            pulse_err_next = 1'b1;
            state_next     = WAIT_SYNC;
        end
    end

    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            state_reg      <= IDLE;
            crc_reg        <= CRC_SEED;
            idx_reg        <= 2'd0;
            status_rx_reg  <= 4'd0;
            data_rx_reg    <= 12'd0;
            data_out_reg   <= 12'd0;
            status_out_reg <= 4'd0;
            we_reg         <= 1'b0;
            valid_reg      <= 1'b0;
            crc_err_reg    <= 1'b0;
            pulse_err_reg  <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            crc_reg        <= crc_next;
            idx_reg        <= idx_next;
            status_rx_reg  <= status_rx_next;
            data_rx_reg    <= data_rx_next;
            data_out_reg   <= data_out_next;
            status_out_reg <= status_out_next;
            we_reg         <= we_next;
            valid_reg      <= valid_next;
            crc_err_reg    <= crc_err_next;
            pulse_err_reg  <= pulse_err_next;
            ovf_reg        <= ovf_next;
        end
    end

    assign data_fast_o       = data_out_reg;
    assign status_o          = status_out_reg;
    assign write_enable_rx_o = we_reg;
    assign frame_valid_o     = valid_reg;
    assign crc_err_o         = crc_err_reg;
    assign pulse_err_o       = pulse_err_reg;
    assign overflow_o        = ovf_reg;

endmodule
